// File: rtl/decoder_queue.sv
// decoder_queue: RV32I decode stage. Fetch pushes {pc, instr} pairs into a
// DEPTH-entry FIFO; the head is decoded combinationally and captured into a
// registered output stage that holds steady while execute stalls.

`ifndef ALU_WIDTH
`define ALU_WIDTH       16
`define ALU_ADD         0
`define ALU_SUB         1
`define ALU_SLT         2
`define ALU_SLTU        3
`define ALU_XOR         4
`define ALU_OR          5
`define ALU_AND         6
`define ALU_SLL         7
`define ALU_SRL         8
`define ALU_SRA         9
`define ALU_EQ          10
`define ALU_NEQ         11
`define ALU_GE          12
`define ALU_GEU         13
`define ALU_LT          14
`define ALU_LTU         15
`define OPCODE_WIDTH    11
`define OPC_RTYPE       0
`define OPC_ITYPE       1
`define OPC_LOAD        2
`define OPC_STORE       3
`define OPC_BRANCH      4
`define OPC_JAL         5
`define OPC_JALR        6
`define OPC_LUI         7
`define OPC_AUIPC       8
`define OPC_SYSTEM      9
`define OPC_FENCE       10
`define EXCEPTION_WIDTH 4
`define EXC_ILLEGAL     0
`define EXC_ECALL       1
`define EXC_EBREAK      2
`define EXC_MRET        3
`endif

module decoder_queue #(
   parameter int DWIDTH    = 32,
   parameter int IWIDTH    = 32,
   parameter int AWIDTH    = 5,
   parameter int PC_WIDTH  = 32,
   parameter int DEPTH     = 4,
   parameter int CNT_WIDTH = 32
) (
   input  logic                        dq_clk,
   input  logic                        dq_rst,
   input  logic                        dq_i_valid,
   output logic                        dq_o_ready,
   input  logic [IWIDTH-1:0]           dq_i_instr,
   input  logic [PC_WIDTH-1:0]         dq_i_pc,
   input  logic                        dq_i_flush,
   output logic                        dq_o_valid,
   input  logic                        dq_i_ready,
   output logic [PC_WIDTH-1:0]         dq_o_pc,
   output logic [AWIDTH-1:0]           dq_o_addr_rs1,
   output logic [AWIDTH-1:0]           dq_o_addr_rs2,
   output logic [AWIDTH-1:0]           dq_o_addr_rd,
   output logic [2:0]                  dq_o_funct3,
   output logic [DWIDTH-1:0]           dq_o_imm,
   output logic [`ALU_WIDTH-1:0]       dq_o_alu,
   output logic [`OPCODE_WIDTH-1:0]    dq_o_opcode,
   output logic [`EXCEPTION_WIDTH-1:0] dq_o_exception,
   output logic [$clog2(DEPTH):0]      dq_o_count,
   output logic [CNT_WIDTH-1:0]        dq_o_issued
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   localparam logic [6:0] OP_RTYPE  = 7'b0110011;
   localparam logic [6:0] OP_ITYPE  = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_SYSTEM = 7'b1110011;
   localparam logic [6:0] OP_FENCE  = 7'b0001111;

   // queue storage and control
   logic [PC_WIDTH-1:0] pc_mem    [DEPTH];
   logic [IWIDTH-1:0]   instr_mem [DEPTH];
   logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0]    count_q, count_d;
   logic                push, load, handshake;

   // output stage
   logic                        valid_q, valid_d;
   logic [PC_WIDTH-1:0]         pc_q, pc_d;
   logic [AWIDTH-1:0]           rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
   logic [2:0]                  f3_q, f3_d;
   logic [DWIDTH-1:0]           imm_q, imm_d;
   logic [`ALU_WIDTH-1:0]       alu_q, alu_d;
   logic [`OPCODE_WIDTH-1:0]    opc_q, opc_d;
   logic [`EXCEPTION_WIDTH-1:0] exc_q, exc_d;
   logic [CNT_WIDTH-1:0]        issued_q, issued_d;

   // decode of the queue head
   logic [31:0]                 ins;
   logic [AWIDTH-1:0]           ins_rs1, ins_rs2, ins_rd;
   logic [31:0]                 imm_i, imm_s, imm_b, imm_j, imm_u, imm_z;
   logic [`ALU_WIDTH-1:0]       arith_alu;
   logic [AWIDTH-1:0]           dec_rs1, dec_rs2, dec_rd;
   logic [2:0]                  dec_f3;
   logic [31:0]                 dec_imm32;
   logic [`ALU_WIDTH-1:0]       dec_alu;
   logic [`OPCODE_WIDTH-1:0]    dec_opc;
   logic [`EXCEPTION_WIDTH-1:0] dec_exc;

   // ready depends only on the registered occupancy, never on dq_i_ready
   assign dq_o_ready = (count_q < CNT_W'(DEPTH));
   assign push       = dq_i_valid && dq_o_ready;
   assign load       = (count_q != '0) && (!valid_q || dq_i_ready);
   assign handshake  = valid_q && dq_i_ready;

   assign ins     = instr_mem[rd_ptr_q][31:0];
   assign ins_rs1 = AWIDTH'(ins[19:15]);
   assign ins_rs2 = AWIDTH'(ins[24:20]);
   assign ins_rd  = AWIDTH'(ins[11:7]);
   assign imm_i   = {{20{ins[31]}}, ins[31:20]};
   assign imm_s   = {{20{ins[31]}}, ins[31:25], ins[11:7]};
   assign imm_b   = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
   assign imm_j   = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
   assign imm_u   = {ins[31:12], 12'b0};
   assign imm_z   = {20'b0, ins[31:20]};

   // write an accepted fetch pair into the slot at the write pointer
   always_ff @(posedge dq_clk) begin
      if (push && !dq_i_flush) begin
         pc_mem[wr_ptr_q]    <= dq_i_pc;
         instr_mem[wr_ptr_q] <= dq_i_instr;
      end
   end

   // ALU op shared by R and I types; SUB only exists for R-type
   always_comb begin
      arith_alu = '0;
      case (ins[14:12])
         3'b000:  arith_alu[(ins[6:0] == OP_RTYPE && ins[30]) ? `ALU_SUB : `ALU_ADD] = 1'b1;
         3'b001:  arith_alu[`ALU_SLL]  = 1'b1;
         3'b010:  arith_alu[`ALU_SLT]  = 1'b1;
         3'b011:  arith_alu[`ALU_SLTU] = 1'b1;
         3'b100:  arith_alu[`ALU_XOR]  = 1'b1;
         3'b101:  arith_alu[ins[30] ? `ALU_SRA : `ALU_SRL] = 1'b1;
         3'b110:  arith_alu[`ALU_OR]   = 1'b1;
         default: arith_alu[`ALU_AND]  = 1'b1;
      endcase
   end

   // full decode of the head instruction, including exception detection
   always_comb begin
      dec_rs1   = '0;
      dec_rs2   = '0;
      dec_rd    = '0;
      dec_f3    = '0;
      dec_imm32 = '0;
      dec_alu   = '0;
      dec_opc   = '0;
      dec_exc   = '0;
      dec_alu[`ALU_ADD] = 1'b1;
      case (ins[6:0])
         OP_RTYPE: begin
            dec_opc[`OPC_RTYPE] = 1'b1;
            dec_rs1 = ins_rs1; dec_rs2 = ins_rs2; dec_rd = ins_rd; dec_f3 = ins[14:12];
            dec_alu = arith_alu;
            if (!(ins[31:25] == 7'b0000000 ||
                  (ins[31:25] == 7'b0100000 && (ins[14:12] == 3'b000 || ins[14:12] == 3'b101))))
               dec_exc[`EXC_ILLEGAL] = 1'b1;
         end
         OP_ITYPE: begin
            dec_opc[`OPC_ITYPE] = 1'b1;
            dec_rs1 = ins_rs1; dec_rd = ins_rd; dec_f3 = ins[14:12]; dec_imm32 = imm_i;
            dec_alu = arith_alu;
            if (ins[14:12] == 3'b001 && ins[31:25] != 7'b0000000)
               dec_exc[`EXC_ILLEGAL] = 1'b1;
            if (ins[14:12] == 3'b101 && ins[31:25] != 7'b0000000 && ins[31:25] != 7'b0100000)
               dec_exc[`EXC_ILLEGAL] = 1'b1;
         end
         OP_LOAD: begin
            dec_opc[`OPC_LOAD] = 1'b1;
            dec_rs1 = ins_rs1; dec_rd = ins_rd; dec_f3 = ins[14:12]; dec_imm32 = imm_i;
         end
         OP_STORE: begin
            dec_opc[`OPC_STORE] = 1'b1;
            dec_rs1 = ins_rs1; dec_rs2 = ins_rs2; dec_f3 = ins[14:12]; dec_imm32 = imm_s;
         end
         OP_BRANCH: begin
            dec_opc[`OPC_BRANCH] = 1'b1;
            dec_rs1 = ins_rs1; dec_rs2 = ins_rs2; dec_f3 = ins[14:12]; dec_imm32 = imm_b;
            dec_alu = '0;
            case (ins[14:12])
               3'b000:  dec_alu[`ALU_EQ]  = 1'b1;
               3'b001:  dec_alu[`ALU_NEQ] = 1'b1;
               3'b100:  dec_alu[`ALU_LT]  = 1'b1;
               3'b101:  dec_alu[`ALU_GE]  = 1'b1;
               3'b110:  dec_alu[`ALU_LTU] = 1'b1;
               3'b111:  dec_alu[`ALU_GEU] = 1'b1;
               default: begin
                  dec_alu[`ALU_ADD]     = 1'b1;
                  dec_exc[`EXC_ILLEGAL] = 1'b1;
               end
            endcase
         end
         OP_JAL: begin
            dec_opc[`OPC_JAL] = 1'b1;
            dec_rd = ins_rd; dec_imm32 = imm_j;
         end
         OP_JALR: begin
            dec_opc[`OPC_JALR] = 1'b1;
            dec_rs1 = ins_rs1; dec_rd = ins_rd; dec_f3 = ins[14:12]; dec_imm32 = imm_i;
         end
         OP_LUI: begin
            dec_opc[`OPC_LUI] = 1'b1;
            dec_rd = ins_rd; dec_imm32 = imm_u;
         end
         OP_AUIPC: begin
            dec_opc[`OPC_AUIPC] = 1'b1;
            dec_rd = ins_rd; dec_imm32 = imm_u;
         end
         OP_SYSTEM: begin
            dec_opc[`OPC_SYSTEM] = 1'b1;
            dec_rs1 = ins_rs1; dec_rd = ins_rd; dec_f3 = ins[14:12]; dec_imm32 = imm_z;
            if (ins[14:12] == 3'b000) begin
               case (ins[31:20])
                  12'h000: dec_exc[`EXC_ECALL]   = 1'b1;
                  12'h001: dec_exc[`EXC_EBREAK]  = 1'b1;
                  12'h302: dec_exc[`EXC_MRET]    = 1'b1;
                  default: dec_exc[`EXC_ILLEGAL] = 1'b1;
               endcase
            end
         end
         OP_FENCE: begin
            dec_opc[`OPC_FENCE] = 1'b1;
            dec_rs1 = ins_rs1; dec_rd = ins_rd; dec_f3 = ins[14:12]; dec_imm32 = imm_z;
         end
         default: dec_exc[`EXC_ILLEGAL] = 1'b1;
      endcase
   end

   // next state for pointers, occupancy, output stage and issue counter;
   // flush wins over push and pop and leaves the issue counter alone
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      valid_d  = valid_q;
      issued_d = issued_q;
      pc_d  = pc_q;  rs1_d = rs1_q; rs2_d = rs2_q; rd_d  = rd_q;
      f3_d  = f3_q;  imm_d = imm_q; alu_d = alu_q; opc_d = opc_q; exc_d = exc_q;
      if (dq_i_flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
         valid_d  = 1'b0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + 1'b1;
         if (load) rd_ptr_d = rd_ptr_q + 1'b1;
         if (push && !load)      count_d = count_q + 1'b1;
         else if (!push && load) count_d = count_q - 1'b1;
         if (handshake) issued_d = issued_q + 1'b1;
         if (load) begin
            valid_d = 1'b1;
            pc_d  = pc_mem[rd_ptr_q];
            rs1_d = dec_rs1; rs2_d = dec_rs2; rd_d = dec_rd; f3_d = dec_f3;
            imm_d = DWIDTH'(dec_imm32);
            alu_d = dec_alu; opc_d = dec_opc; exc_d = dec_exc;
         end else if (handshake) begin
            valid_d = 1'b0;
         end
      end
   end

   // state register; reset clears everything and overrides flush and push
   always_ff @(posedge dq_clk) begin
      if (dq_rst) begin
         wr_ptr_q <= '0; rd_ptr_q <= '0; count_q <= '0; valid_q <= 1'b0; issued_q <= '0;
         pc_q  <= '0; rs1_q <= '0; rs2_q <= '0; rd_q  <= '0;
         f3_q  <= '0; imm_q <= '0; alu_q <= '0; opc_q <= '0; exc_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d; rd_ptr_q <= rd_ptr_d; count_q <= count_d;
         valid_q  <= valid_d;  issued_q <= issued_d;
         pc_q  <= pc_d;  rs1_q <= rs1_d; rs2_q <= rs2_d; rd_q  <= rd_d;
         f3_q  <= f3_d;  imm_q <= imm_d; alu_q <= alu_d; opc_q <= opc_d; exc_q <= exc_d;
      end
   end

   assign dq_o_valid     = valid_q;
   assign dq_o_pc        = pc_q;
   assign dq_o_addr_rs1  = rs1_q;
   assign dq_o_addr_rs2  = rs2_q;
   assign dq_o_addr_rd   = rd_q;
   assign dq_o_funct3    = f3_q;
   assign dq_o_imm       = imm_q;
   assign dq_o_alu       = alu_q;
   assign dq_o_opcode    = opc_q;
   assign dq_o_exception = exc_q;
   assign dq_o_count     = count_q;
   assign dq_o_issued    = issued_q;

endmodule

// File: tb/tb_decoder_queue.sv
// Bench for decoder_queue: directed scenarios plus random traffic, with a
// reference decoder feeding a scoreboard that a negedge monitor drains.

`ifndef ALU_WIDTH
`define ALU_WIDTH       16
`define ALU_ADD         0
`define ALU_SUB         1
`define ALU_SLT         2
`define ALU_SLTU        3
`define ALU_XOR         4
`define ALU_OR          5
`define ALU_AND         6
`define ALU_SLL         7
`define ALU_SRL         8
`define ALU_SRA         9
`define ALU_EQ          10
`define ALU_NEQ         11
`define ALU_GE          12
`define ALU_GEU         13
`define ALU_LT          14
`define ALU_LTU         15
`define OPCODE_WIDTH    11
`define OPC_RTYPE       0
`define OPC_ITYPE       1
`define OPC_LOAD        2
`define OPC_STORE       3
`define OPC_BRANCH      4
`define OPC_JAL         5
`define OPC_JALR        6
`define OPC_LUI         7
`define OPC_AUIPC       8
`define OPC_SYSTEM      9
`define OPC_FENCE       10
`define EXCEPTION_WIDTH 4
`define EXC_ILLEGAL     0
`define EXC_ECALL       1
`define EXC_EBREAK      2
`define EXC_MRET        3
`endif

module tb_decoder_queue;
   localparam int DEPTH = 4;

   logic        clk = 1'b0, rst = 1'b1, i_valid = 1'b0, flush = 1'b0, i_ready = 1'b0;
   logic [31:0] i_instr = '0, i_pc = '0;
   logic        o_ready, o_valid;
   logic [31:0] o_pc, o_imm, o_issued;
   logic [4:0]  o_rs1, o_rs2, o_rd;
   logic [2:0]  o_f3, o_count;
   logic [`ALU_WIDTH-1:0]       o_alu;
   logic [`OPCODE_WIDTH-1:0]    o_opc;
   logic [`EXCEPTION_WIDTH-1:0] o_exc;

   decoder_queue #(.DEPTH(DEPTH)) dut (
      .dq_clk(clk), .dq_rst(rst), .dq_i_valid(i_valid), .dq_o_ready(o_ready),
      .dq_i_instr(i_instr), .dq_i_pc(i_pc), .dq_i_flush(flush), .dq_o_valid(o_valid),
      .dq_i_ready(i_ready), .dq_o_pc(o_pc), .dq_o_addr_rs1(o_rs1), .dq_o_addr_rs2(o_rs2),
      .dq_o_addr_rd(o_rd), .dq_o_funct3(o_f3), .dq_o_imm(o_imm), .dq_o_alu(o_alu),
      .dq_o_opcode(o_opc), .dq_o_exception(o_exc), .dq_o_count(o_count), .dq_o_issued(o_issued)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] pc;
      logic [4:0]  rs1, rs2, rd;
      logic [2:0]  f3;
      logic [31:0] imm;
      logic [`ALU_WIDTH-1:0]       alu;
      logic [`OPCODE_WIDTH-1:0]    opc;
      logic [`EXCEPTION_WIDTH-1:0] exc;
   } rec_t;

   rec_t        sb[$];
   rec_t        got, hold_snap;
   bit          hold_pend = 0, mon_en = 0;
   int          vectors = 0, miscompares = 0;
   logic [31:0] exp_issued = '0;

   assign got = {o_pc, o_rs1, o_rs2, o_rd, o_f3, o_imm, o_alu, o_opc, o_exc};

   function automatic int arith_op(input logic [2:0] f3, input logic alt, input bit is_r);
      int tbl[8];
      tbl = '{`ALU_ADD, `ALU_SLL, `ALU_SLT, `ALU_SLTU, `ALU_XOR, `ALU_SRL, `ALU_OR, `ALU_AND};
      if (alt && is_r && f3 == 3'd0) return `ALU_SUB;
      if (alt && f3 == 3'd5) return `ALU_SRA;
      return tbl[f3];
   endfunction

   // reference decoder: immediates built with signed arithmetic on the fields
   function automatic rec_t ref_decode(input logic [31:0] i, input logic [31:0] pc);
      rec_t e;
      int alu, imm, cls, sgn;
      bit r1, r2, rd, keep_f3, ill;
      logic [2:0] f3;
      logic [6:0] f7;
      f3 = i[14:12]; f7 = i[31:25]; sgn = i[31] ? 1 : 0;
      alu = `ALU_ADD; imm = 0; cls = -1; r1 = 0; r2 = 0; rd = 0; keep_f3 = 1; ill = 0;
      e = '0; e.pc = pc;
      case (i[6:0])
         7'h33: begin cls = `OPC_RTYPE; r1 = 1; r2 = 1; rd = 1; alu = arith_op(f3, i[30], 1);
                   if (!(f7 == 7'h00 || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)))) ill = 1; end
         7'h13: begin cls = `OPC_ITYPE; r1 = 1; rd = 1; alu = arith_op(f3, i[30], 0);
                   imm = -2048 * sgn + int'(i[30:20]);
                   if (f3 == 3'd1 && f7 != 7'h00) ill = 1;
                   if (f3 == 3'd5 && f7 != 7'h00 && f7 != 7'h20) ill = 1; end
         7'h03: begin cls = `OPC_LOAD; r1 = 1; rd = 1; imm = -2048 * sgn + int'(i[30:20]); end
         7'h67: begin cls = `OPC_JALR; r1 = 1; rd = 1; imm = -2048 * sgn + int'(i[30:20]); end
         7'h23: begin cls = `OPC_STORE; r1 = 1; r2 = 1;
                   imm = -2048 * sgn + int'(i[30:25]) * 32 + int'(i[11:7]); end
         7'h63: begin cls = `OPC_BRANCH; r1 = 1; r2 = 1;
                   imm = -4096 * sgn + int'(i[7]) * 2048 + int'(i[30:25]) * 32 + int'(i[11:8]) * 2;
                   case (f3)
                      3'd0: alu = `ALU_EQ;  3'd1: alu = `ALU_NEQ; 3'd4: alu = `ALU_LT;
                      3'd5: alu = `ALU_GE;  3'd6: alu = `ALU_LTU; 3'd7: alu = `ALU_GEU;
                      default: ill = 1;
                   endcase end
         7'h6F: begin cls = `OPC_JAL; rd = 1; keep_f3 = 0;
                   imm = -1048576 * sgn + int'(i[19:12]) * 4096 + int'(i[20]) * 2048 + int'(i[30:21]) * 2; end
         7'h37: begin cls = `OPC_LUI; rd = 1; keep_f3 = 0; imm = int'(i & 32'hFFFFF000); end
         7'h17: begin cls = `OPC_AUIPC; rd = 1; keep_f3 = 0; imm = int'(i & 32'hFFFFF000); end
         7'h73: begin cls = `OPC_SYSTEM; r1 = 1; rd = 1; imm = int'(i[31:20]);
                   if (f3 == 3'd0) begin
                      if (i[31:20] == 12'h000)      e.exc[`EXC_ECALL] = 1'b1;
                      else if (i[31:20] == 12'h001) e.exc[`EXC_EBREAK] = 1'b1;
                      else if (i[31:20] == 12'h302) e.exc[`EXC_MRET] = 1'b1;
                      else ill = 1;
                   end end
         7'h0F: begin cls = `OPC_FENCE; r1 = 1; rd = 1; imm = int'(i[31:20]); end
         default: begin keep_f3 = 0; ill = 1; end
      endcase
      e.rs1 = r1 ? i[19:15] : 5'd0;
      e.rs2 = r2 ? i[24:20] : 5'd0;
      e.rd  = rd ? i[11:7]  : 5'd0;
      e.f3  = keep_f3 ? f3 : 3'd0;
      e.imm = imm;
      e.alu[alu] = 1'b1;
      if (cls >= 0) e.opc[cls] = 1'b1;
      if (ill) e.exc[`EXC_ILLEGAL] = 1'b1;
      return e;
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [31:0] w;
      logic [6:0]  ops[11];
      logic [11:0] sys[3];
      ops = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h73, 7'h0F};
      sys = '{12'h000, 12'h001, 12'h302};
      w = $urandom();
      if ($urandom_range(0, 9) != 0) w[6:0] = ops[$urandom_range(0, 10)];
      if ($urandom_range(0, 2) != 0) w[31:25] = ($urandom_range(0, 1) != 0) ? 7'h00 : 7'h20;
      if (w[6:0] == 7'h73 && $urandom_range(0, 1) != 0) begin
         w[14:12] = 3'd0;
         w[31:20] = sys[$urandom_range(0, 2)];
      end
      return w;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // drive one cycle; an accepted push records its expected decode
   task automatic step(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic rdy, input logic fl, output bit acc);
      i_valid = v; i_instr = ins; i_pc = pc; i_ready = rdy; flush = fl;
      acc = v && o_ready && !fl && !rst;
      if (acc) sb.push_back(ref_decode(ins, pc));
      @(posedge clk); #1;
   endtask

   // monitor: checks the issue counter, hold stability and each handed-off decode
   always @(negedge clk) begin
      if (mon_en) begin
         vectors++;
         if (o_issued !== exp_issued) begin
            miscompares++;
            $display("FAIL issued: got %0d expected %0d", o_issued, exp_issued);
         end
         if (hold_pend) begin
            vectors++;
            if (got !== hold_snap) begin
               miscompares++;
               $display("FAIL hold: got %h expected %h", got, hold_snap);
            end
         end
         hold_pend = 0;
         if (rst) begin
            sb.delete();
            exp_issued = '0;
         end else if (flush) begin
            sb.delete();
         end else if (o_valid) begin
            if (i_ready) begin
               vectors++;
               if (sb.size() == 0) begin
                  miscompares++;
                  $display("FAIL unexpected: got pc %h expected no output", o_pc);
               end else begin
                  rec_t e;
                  e = sb.pop_front();
                  if (got !== e) begin
                     miscompares++;
                     $display("FAIL decode pc=%h: got %h expected %h", e.pc, got, e);
                  end
               end
               exp_issued = exp_issued + 1;
            end else begin
               hold_snap = got;
               hold_pend = 1;
            end
         end
      end
   end

   task automatic check_zero(input string tag);
      check({tag, " valid"}, 32'(o_valid), 0);
      check({tag, " count"}, 32'(o_count), 0);
      check({tag, " ready"}, 32'(o_ready), 1);
      check({tag, " fields"}, 32'(|got), 0);
   endtask

   initial begin
      bit          acc;
      int          nacc;
      logic [31:0] pc, encs[5];
      logic [3:0]  excs[5];

      // reset
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      mon_en = 1;
      check_zero("reset");
      check("reset issued", o_issued, 0);

      // single ADDI x1, x2, -5
      step(1'b1, 32'hFFB10093, 32'h100, 1'b1, 1'b0, acc);
      step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, acc);
      check("addi valid", 32'(o_valid), 1);
      check("addi rs1", 32'(o_rs1), 2);
      check("addi rs2", 32'(o_rs2), 0);
      check("addi rd", 32'(o_rd), 1);
      check("addi imm", o_imm, 32'hFFFFFFFB);
      check("addi alu", 32'(o_alu), 32'h1);
      check("addi opc", 32'(o_opc), 32'h2);
      check("addi exc", 32'(o_exc), 0);
      step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, acc);
      check("addi issued", o_issued, 1);

      // six back-to-back pushes against a stalled output
      nacc = 0;
      for (int n = 0; n < 6; n++) begin
         step(1'b1, rand_instr(), 32'h200 + 32'(4 * n), 1'b0, 1'b0, acc);
         nacc += int'(acc);
      end
      check("stall accepted", 32'(nacc), 5);
      check("stall count", 32'(o_count), 4);
      check("stall ready", 32'(o_ready), 0);
      check("stall pc", o_pc, 32'h200);
      for (int n = 0; n < 8; n++) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, acc);
      check("drain1 left", 32'(sb.size()), 0);
      check("drain1 valid", 32'(o_valid), 0);

      // steady half-full stream across pointer wrap
      pc = 32'h400;
      for (int n = 0; n < 3; n++) begin step(1'b1, rand_instr(), pc, 1'b0, 1'b0, acc); pc += 4; end
      for (int n = 0; n < 2 * DEPTH + 3; n++) begin
         step(1'b1, rand_instr(), pc, 1'b1, 1'b0, acc);
         pc += 4;
         check("steady count", 32'(o_count), 2);
      end
      for (int n = 0; n < 6; n++) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, acc);
      check("drain2 left", 32'(sb.size()), 0);

      // flush a full queue while a push is offered
      for (int n = 0; n < 10 && o_ready; n++) begin
         step(1'b1, rand_instr(), pc, 1'b0, 1'b0, acc);
         pc += 4;
      end
      check("full ready", 32'(o_ready), 0);
      check("full count", 32'(o_count), 4);
      step(1'b1, 32'h00500093, 32'hDEAD0, 1'b0, 1'b1, acc);
      check("flush valid", 32'(o_valid), 0);
      check("flush count", 32'(o_count), 0);
      check("flush ready", 32'(o_ready), 1);
      check("flush issued", o_issued, exp_issued);
      for (int n = 0; n < 3; n++) begin
         step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, acc);
         check("post-flush valid", 32'(o_valid), 0);
      end

      // system and illegal encodings
      encs = '{32'h00000073, 32'h00100073, 32'h30200073, 32'h40001013, 32'h0000207F};
      excs = '{4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0001};
      for (int n = 0; n < 5; n++) begin
         step(1'b1, encs[n], 32'h800 + 32'(4 * n), 1'b1, 1'b0, acc);
         step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, acc);
         check("exc valid", 32'(o_valid), 1);
         check("exc bits", 32'(o_exc), 32'(excs[n]));
         step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, acc);
      end

      // random traffic with occasional flush
      pc = 32'h1000;
      for (int n = 0; n < 400; n++) begin
         step($urandom_range(0, 3) != 0, rand_instr(), pc, $urandom_range(0, 3) != 0,
              $urandom_range(0, 49) == 0, acc);
         pc += 4;
      end
      for (int n = 0; n < 8; n++) step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, acc);
      check("drain3 left", 32'(sb.size()), 0);

      // reset with entries queued and the output stalled
      for (int n = 0; n < 4; n++) begin step(1'b1, rand_instr(), pc, 1'b0, 1'b0, acc); pc += 4; end
      check("pre-rst count", 32'(o_count), 3);
      check("pre-rst valid", 32'(o_valid), 1);
      rst = 1'b1;
      step(1'b1, rand_instr(), pc, 1'b0, 1'b1, acc);
      check_zero("rst");
      check("rst issued", o_issued, 0);
      rst = 1'b0;
      step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, acc);
      check("after rst valid", 32'(o_valid), 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/decoder_queue.md
Name: decoder_queue

Overview:
RV32I decode stage with a parametrised instruction queue between fetch and execute.
- Fetch pushes {pc, instr} pairs into a DEPTH-entry FIFO through a valid/ready handshake.
- The FIFO head is decoded combinationally and captured in a registered output stage held under backpressure.
- Flush empties the whole stage. Exceptions are fully decoded and flow with their instruction.

Parameters:
- DWIDTH, 32, immediate/data width.
- IWIDTH, 32, instruction width.
- AWIDTH, 5, register address width.
- PC_WIDTH, 32, program counter width.
- DEPTH, 4, queue entries; power of 2, >= 2.
- CNT_WIDTH, 32, width of the issued-instruction counter.

Ports:
- dq_clk  input  1  clock, all logic on rising edge.
- dq_rst  input  1  synchronous active-high reset.
- dq_i_valid  input  1  fetch offers {instr, pc}.
- dq_o_ready  output  1  queue can accept; = (count < DEPTH).
- dq_i_instr  input  IWIDTH  instruction word.
- dq_i_pc  input  PC_WIDTH  instruction PC.
- dq_i_flush  input  1  discard queue and output stage.
- dq_o_valid  output  1  output stage holds a decoded instruction.
- dq_i_ready  input  1  execute accepts the output (low = stall).
- dq_o_pc  output  PC_WIDTH  PC of the decoded instruction.
- dq_o_addr_rs1, dq_o_addr_rs2, dq_o_addr_rd  output  AWIDTH each  register indices; 0 when the field is unused.
- dq_o_funct3  output  3  funct3; 0 for U/J types.
- dq_o_imm  output  DWIDTH  sign/zero-extended immediate.
- dq_o_alu  output  `ALU_WIDTH  one-hot ALU op, header.vh bit indices.
- dq_o_opcode  output  `OPCODE_WIDTH  one-hot opcode class, header.vh indices.
- dq_o_exception  output  `EXCEPTION_WIDTH  ILLEGAL/ECALL/EBREAK/MRET bits.
- dq_o_count  output  $clog2(DEPTH)+1  queue occupancy.
- dq_o_issued  output  CNT_WIDTH  count of instructions handed to execute; wraps.

Behaviour:
- Reset is sampled at the rising edge while dq_rst = 1.
  - Pointers and count go to 0 and dq_o_valid to 0.
  - All registered outputs go to 0, and dq_o_issued to 0.
  - dq_o_ready is 1 in the cycle after reset.
  - Reset overrides flush and push in the same cycle.
- Push: when dq_i_valid && dq_o_ready, write to the slot at wr_ptr, then wr_ptr++ (mod DEPTH).
  - Ready depends only on count, with no combinational path from dq_i_ready.
  - While full, a push is refused even if a pop happens in the same cycle.
- Load (pop): when count > 0 && (!dq_o_valid || dq_i_ready).
  - The output stage captures the decode of the head, dq_o_valid <= 1, and rd_ptr++.
  - When the last entry leaves and no new entry can load, dq_o_valid <= 0 after the handshake completes.
- Handshake and hold:
  - dq_i_ready is sampled only when dq_o_valid = 1. dq_o_issued increments on each dq_o_valid && dq_i_ready.
  - While dq_o_valid && !dq_i_ready, every dq_o_* output is held bit-stable.
- Count: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
- Latency: an instruction accepted at edge k appears with dq_o_valid = 1 after edge k+1 when the queue was empty. Full throughput is 1 instruction/cycle.
- Flush: dq_i_flush at an edge clears the pointers, count and dq_o_valid, and drops any same-cycle push. Flush has priority over push and pop; dq_o_issued is not changed.
- Decode opcode classes: RTYPE, ITYPE, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, SYSTEM, FENCE. Any other opcode sets ILLEGAL, leaves the opcode vector 0 and sets the ALU vector to ADD.
- Register fields:
  - R: rs1, rs2, rd.
  - I/LOAD/JALR/SYSTEM/FENCE: rs1, rd.
  - S/B: rs1, rs2.
  - U/J: rd.
- Immediates:
  - I/LOAD/JALR: sext [31:20].
  - S: sext {[31:25], [11:7]}.
  - B: sext {[31], [7], [30:25], [11:8], 0}.
  - J: sext {[31], [19:12], [20], [30:21], 0}.
  - U: {[31:12], 12'b0}.
  - SYSTEM/FENCE: zext [31:20].
  - R: 0.
- ALU decode:
  - R-type: funct3 000 gives ADD if [30] = 0, else SUB; 101 gives SRL or SRA by [30]. Other funct3 values map directly to SLL, SLT, SLTU, XOR, OR, AND.
  - I-type: the same mapping, except no SUB.
  - BRANCH: EQ, NEQ, LT, GE, LTU, GEU.
  - All other classes: ADD.
- ILLEGAL is also set for:
  - R-type funct7 other than 0000000, or 0100000 used with any funct3 other than 000/101.
  - SLLI with [31:25] != 0.
  - SRLI/SRAI with [31:25] not 0000000 or 0100000.
  - BRANCH funct3 010 or 011.
  - SYSTEM funct3 = 0 with [31:20] not 0x000, 0x001 or 0x302.
- SYSTEM funct3 = 0 exceptions: [31:20] = 0x000 sets ECALL, 0x001 sets EBREAK, 0x302 sets MRET.
- An instruction with an exception still issues with dq_o_valid = 1. Its exception bits are registered together with the rest of its fields.

Test Plan:
- Reset, then push ADDI x1, x2, -5 (0xFFB10093) at pc 0x100 → two edges later: valid = 1, rs1 = 2, rd = 1, rs2 = 0, imm = 0xFFFFFFFB, ALU ADD, opcode ITYPE, exception = 0, issued = 1.
- Push 6 instructions back-to-back with dq_i_ready = 0 → dq_o_ready drops after the 5th is accepted (4 queued + 1 in output), count = 4, outputs held stable. Raise ready → all 5 issue in order, one per cycle, pcs verified.
- Keep the queue half full with simultaneous push and pop for 2*DEPTH+3 cycles → count is constant, order is preserved across pointer wrap.
- Queue full plus dq_i_flush with dq_i_valid = 1 → next cycle count = 0, valid = 0, ready = 1; the flushed-cycle instruction never appears; issued is unchanged.
- Encodings 0x00000073, 0x00100073, 0x30200073, 0x40001013 (SLLI with bad funct7), 0x0000207F → ECALL, EBREAK, MRET, ILLEGAL, ILLEGAL respectively, each issued with valid = 1.
- Assert dq_rst with 3 entries queued and a stalled output → next cycle count = 0, valid = 0, all outputs 0, issued = 0.
